// File: rtl/ip_fifo_peripheral.sv
`default_nettype none
// ============================================================================
// Module   : ip_fifo_peripheral
// Purpose  : 32-bit data FIFO on the IP side of a Wishbone subordinate.
//            Writes to DATA (0x20) push and reads pop, so single and block
//            bus transfers act as FIFO streams. The block also exposes LEVEL,
//            THRESHOLD and ERR registers, plus status and IRQ pulses for the
//            subordinate's standard registers.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Register map (full 16-bit address decode):
//   0x20 DATA      : write pushes, read pops (an empty pop returns 0)
//   0x24 LEVEL     : read-only entry count
//   0x28 THRESHOLD : read/write, low log2(DEPTH)+1 bits
//   0x2C ERR       : bit0 overflow, bit1 underflow; write 1 to clear
//   0x30 PUSHCNT   : only when IP_FIFO_PUSHCNT_EN is defined; otherwise unmapped
// Ports:
//   i_wb_clk / i_wb_rst_n : clock and asynchronous active-low reset
//   i_ip_address          : byte address
//   i_ip_wdata            : write data
//   o_ip_rdata            : registered read data, valid while o_ip_ack is high
//   i_ip_write_en         : write request (has priority over a read)
//   i_ip_read_en          : read request
//   o_ip_ack              : one-cycle acknowledge for each accepted request
//   o_ip_stall            : high while FLUSH is high; requests are ignored
//   i_ip_control          : bit0 = FLUSH
//   o_ip_status           : {16'b0, LEVEL[7:0], 4'b0, udf, ovf, full, empty}
//   o_ip_irq              : pulses {28'b0, drained, udf, ovf, threshold}
// Optional feature macro: IP_FIFO_PUSHCNT_EN
// ============================================================================
module ip_fifo_peripheral #(
  parameter int DEPTH      = 16,
  parameter int THRESH_RST = DEPTH / 2
) (
  input  logic        i_wb_clk,
  input  logic        i_wb_rst_n,
  input  logic [15:0] i_ip_address,
  input  logic [31:0] i_ip_wdata,
  output logic [31:0] o_ip_rdata,
  input  logic        i_ip_write_en,
  input  logic        i_ip_read_en,
  output logic        o_ip_ack,
  output logic        o_ip_stall,
  input  logic [31:0] i_ip_control,
  output logic [31:0] o_ip_status,
  output logic [31:0] o_ip_irq
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  localparam logic [15:0] ADDR_DATA    = 16'h0020;
  localparam logic [15:0] ADDR_LEVEL   = 16'h0024;
  localparam logic [15:0] ADDR_THRESH  = 16'h0028;
  localparam logic [15:0] ADDR_ERR     = 16'h002C;
`ifdef IP_FIFO_PUSHCNT_EN
  localparam logic [15:0] ADDR_PUSHCNT = 16'h0030;
`endif

  // Storage has no reset: its contents are only visible through the pointers.
  logic [31:0]   mem_q [DEPTH];

  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [1:0]    err_q, err_d;
  logic [PW-1:0] thresh_q, thresh_d;
  logic          ack_q, ack_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          ovf_ev_q, ovf_ev_d;
  logic          udf_ev_q, udf_ev_d;
  logic          drain_ev_q, drain_ev_d;
  logic [PW-1:0] level_last_q;
  logic [31:0]   status_q;
  logic [31:0]   irq_q;
`ifdef IP_FIFO_PUSHCNT_EN
  logic [31:0]   pushcnt_q, pushcnt_d;
`endif

  logic          flush;
  logic          push_en;
  logic          empty;
  logic          full;
  logic [PW-1:0] level;
  logic          thr_cross;
  logic          unused_ctrl;

  assign flush       = i_ip_control[0];
  assign unused_ctrl = |i_ip_control[31:1];
  assign o_ip_stall  = flush;

  // Pointers carry one extra wrap bit so that full and empty differ.
  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[PW-1] != rptr_q[PW-1]) &&
                 (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign level = wptr_q - rptr_q;

  // The level registered last cycle is the value before the most recent
  // pointer update, so this catches the update that first reached THRESHOLD.
  assign thr_cross = (thresh_q != '0) && (level_last_q < thresh_q) &&
                     (level >= thresh_q);

  always_comb begin
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    err_d      = err_q;
    thresh_d   = thresh_q;
    ack_d      = 1'b0;
    rdata_d    = '0;
    push_en    = 1'b0;
    ovf_ev_d   = 1'b0;
    udf_ev_d   = 1'b0;
    drain_ev_d = 1'b0;
`ifdef IP_FIFO_PUSHCNT_EN
    pushcnt_d  = pushcnt_q;
`endif

    if (flush) begin
      // Flush wins over any request presented in the same cycle.
      wptr_d    = '0;
      rptr_d    = '0;
      err_d     = '0;
`ifdef IP_FIFO_PUSHCNT_EN
      pushcnt_d = '0;
`endif
    end else if (i_ip_write_en) begin
      ack_d = 1'b1;
      case (i_ip_address)
        ADDR_DATA: begin
          if (full) begin
            err_d[0] = 1'b1;
            ovf_ev_d = 1'b1;
          end else begin
            push_en   = 1'b1;
            wptr_d    = wptr_q + PW'(1);
`ifdef IP_FIFO_PUSHCNT_EN
            pushcnt_d = pushcnt_q + 32'd1;
`endif
          end
        end
        ADDR_THRESH: thresh_d = i_ip_wdata[PW-1:0];
        ADDR_ERR:    err_d    = err_q & ~i_ip_wdata[1:0];
`ifdef IP_FIFO_PUSHCNT_EN
        ADDR_PUSHCNT: pushcnt_d = '0;
`endif
        default: ;
      endcase
    end else if (i_ip_read_en) begin
      ack_d = 1'b1;
      case (i_ip_address)
        ADDR_DATA: begin
          if (empty) begin
            err_d[1] = 1'b1;
            udf_ev_d = 1'b1;
          end else begin
            rdata_d    = mem_q[rptr_q[AW-1:0]];
            rptr_d     = rptr_q + PW'(1);
            drain_ev_d = (level == PW'(1));
          end
        end
        ADDR_LEVEL:   rdata_d = 32'(level);
        ADDR_THRESH:  rdata_d = 32'(thresh_q);
        ADDR_ERR:     rdata_d = {30'b0, err_q};
`ifdef IP_FIFO_PUSHCNT_EN
        ADDR_PUSHCNT: rdata_d = pushcnt_q;
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_wb_clk) begin
    if (push_en) begin
      mem_q[wptr_q[AW-1:0]] <= i_ip_wdata;
    end
  end

  always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
    if (!i_wb_rst_n) begin
      wptr_q       <= '0;
      rptr_q       <= '0;
      err_q        <= '0;
      thresh_q     <= PW'(THRESH_RST);
      ack_q        <= 1'b0;
      rdata_q      <= '0;
      ovf_ev_q     <= 1'b0;
      udf_ev_q     <= 1'b0;
      drain_ev_q   <= 1'b0;
      level_last_q <= '0;
      status_q     <= 32'h0000_0001;
      irq_q        <= '0;
`ifdef IP_FIFO_PUSHCNT_EN
      pushcnt_q    <= '0;
`endif
    end else begin
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      err_q        <= err_d;
      thresh_q     <= thresh_d;
      ack_q        <= ack_d;
      rdata_q      <= rdata_d;
      ovf_ev_q     <= ovf_ev_d;
      udf_ev_q     <= udf_ev_d;
      drain_ev_q   <= drain_ev_d;
      level_last_q <= level;
      // Status and IRQs are built from state already updated by the
      // request edge, so they trail the ack by one cycle.
      status_q     <= {16'b0, 8'(level), 4'b0, err_q[1], err_q[0], full, empty};
      irq_q        <= {28'b0, drain_ev_q, udf_ev_q, ovf_ev_q, thr_cross};
`ifdef IP_FIFO_PUSHCNT_EN
      pushcnt_q    <= pushcnt_d;
`endif
    end
  end

  assign o_ip_ack    = ack_q;
  assign o_ip_rdata  = rdata_q;
  assign o_ip_status = status_q;
  assign o_ip_irq    = irq_q;

endmodule
`default_nettype wire

// File: tb/tb_ip_fifo_peripheral.sv
`default_nettype none
// ============================================================================
// Module   : tb_ip_fifo_peripheral
// Purpose  : Directed self-checking bench for ip_fifo_peripheral (DEPTH=16).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ip_fifo_peripheral;

  logic        clk;
  logic        rst_n;
  logic [15:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        we;
  logic        re;
  logic        ack;
  logic        stall;
  logic [31:0] ctrl;
  logic [31:0] status;
  logic [31:0] irq;

  int n_checks = 0;
  int n_errors = 0;
  int irq_cnt [4];

  ip_fifo_peripheral #(.DEPTH(16)) dut (
    .i_wb_clk      (clk),
    .i_wb_rst_n    (rst_n),
    .i_ip_address  (addr),
    .i_ip_wdata    (wdata),
    .o_ip_rdata    (rdata),
    .i_ip_write_en (we),
    .i_ip_read_en  (re),
    .o_ip_ack      (ack),
    .o_ip_stall    (stall),
    .i_ip_control  (ctrl),
    .o_ip_status   (status),
    .o_ip_irq      (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count irq pulses, sampled away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int b = 0; b < 4; b++) irq_cnt[b] = irq_cnt[b] + int'(irq[b]);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Present one request; returns ack and data sampled 1 ns after the edge.
  task automatic req(input logic w, input logic r, input logic [15:0] a,
                     input logic [31:0] d, output logic k, output logic [31:0] q);
    @(negedge clk);
    we = w; re = r; addr = a; wdata = d;
    @(posedge clk);
    #1;
    k = ack;
    q = rdata;
  endtask

  task automatic idle();
    @(negedge clk);
    we = 1'b0; re = 1'b0;
  endtask

  task automatic settle(input int n);
    repeat (n) @(negedge clk);
    #2;
  endtask

  task automatic wr(input string tag, input logic [15:0] a, input logic [31:0] d);
    logic k;
    logic [31:0] q;
    req(1'b1, 1'b0, a, d, k, q);
    check({tag, "_ack"}, {31'b0, k}, 32'd1);
    idle();
  endtask

  task automatic rd(input string tag, input logic [15:0] a, input logic [31:0] exp);
    logic k;
    logic [31:0] q;
    req(1'b0, 1'b1, a, 32'h0, k, q);
    check({tag, "_ack"}, {31'b0, k}, 32'd1);
    check(tag, q, exp);
    idle();
  endtask

  initial begin
    logic        k;
    logic [31:0] q;
    logic [31:0] pat [4];
    int          base;
    pat[0] = 32'h12345678; pat[1] = 32'h34567812;
    pat[2] = 32'h56781234; pat[3] = 32'h78123456;
    for (int b = 0; b < 4; b++) irq_cnt[b] = 0;
    rst_n = 1'b0; we = 1'b0; re = 1'b0; addr = '0; wdata = '0; ctrl = '0;

    // ---- Reset state
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_status", status, 32'h0000_0001);
    check("rst_irq",    irq,    32'h0);
    check("rst_ack",    {31'b0, ack},   32'h0);
    check("rst_stall",  {31'b0, stall}, 32'h0);
    check("rst_rdata",  rdata,  32'h0);
    rd("rst_level",  16'h0024, 32'd0);
    rd("rst_thresh", 16'h0028, 32'd8);

    // ---- Four back-to-back writes, four back-to-back reads
    for (int i = 0; i < 4; i++) begin
      req(1'b1, 1'b0, 16'h0020, pat[i], k, q);
      check("burst_wr_ack", {31'b0, k}, 32'd1);
    end
    idle();
    settle(2);
    check("burst_status4", status, 32'h0000_0400);
    base = irq_cnt[3];
    for (int i = 0; i < 4; i++) begin
      req(1'b0, 1'b1, 16'h0020, 32'h0, k, q);
      check("burst_rd_ack", {31'b0, k}, 32'd1);
      check("burst_rd_data", q, pat[i]);
    end
    idle();
    settle(2);
    check("burst_irq3", irq_cnt[3] - base, 32'd1);
    rd("burst_level", 16'h0024, 32'd0);

    // ---- Fill to full, then overflow
    for (int i = 0; i < 16; i++) begin
      req(1'b1, 1'b0, 16'h0020, 32'hA0 + i, k, q);
    end
    idle();
    base = irq_cnt[1];
    wr("ovf_push", 16'h0020, 32'hDEAD_BEEF);
    settle(3);
    check("ovf_status", status, 32'h0000_1006);
    check("ovf_irq1", irq_cnt[1] - base, 32'd1);
    rd("ovf_err", 16'h002C, 32'h1);
    wr("ovf_clr", 16'h002C, 32'h1);
    rd("ovf_err_clr", 16'h002C, 32'h0);
    for (int i = 0; i < 16; i++) begin
      req(1'b0, 1'b1, 16'h0020, 32'h0, k, q);
      check("drain_data", q, 32'hA0 + i);
    end
    idle();
    rd("drain_level", 16'h0024, 32'd0);

    // ---- Underflow
    base = irq_cnt[2];
    rd("udf_data", 16'h0020, 32'h0);
    settle(2);
    check("udf_irq2", irq_cnt[2] - base, 32'd1);
    check("udf_status", status, 32'h0000_0009);
    rd("udf_err", 16'h002C, 32'h2);
    rd("udf_level", 16'h0024, 32'd0);
    wr("udf_clr", 16'h002C, 32'h2);

    // ---- Threshold crossing
    wr("thr_set", 16'h0028, 32'd3);
    base = irq_cnt[0];
    wr("thr_p1", 16'h0020, 32'h1);
    wr("thr_p2", 16'h0020, 32'h2);
    settle(2);
    check("thr_before", irq_cnt[0] - base, 32'd0);
    wr("thr_p3", 16'h0020, 32'h3);
    settle(2);
    check("thr_cross", irq_cnt[0] - base, 32'd1);
    wr("thr_p4", 16'h0020, 32'h4);
    settle(2);
    check("thr_no_repeat", irq_cnt[0] - base, 32'd1);

    // ---- Flush with a write presented
    for (int i = 0; i < 5; i++) wr("fl_push", 16'h0020, 32'hF0 + i);
    settle(2);
    base = irq_cnt[3];
    @(negedge clk);
    ctrl = 32'h1; we = 1'b1; addr = 16'h0020; wdata = 32'hBAD0_0001;
    #1;
    check("fl_stall", {31'b0, stall}, 32'd1);
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      check("fl_ack", {31'b0, ack}, 32'd0);
    end
    @(negedge clk);
    ctrl = 32'h0; we = 1'b0;
    #1;
    check("fl_stall_off", {31'b0, stall}, 32'd0);
    settle(2);
    check("fl_irq3", irq_cnt[3] - base, 32'd0);
    check("fl_status", status, 32'h0000_0001);
    rd("fl_level", 16'h0024, 32'd0);
    rd("fl_thresh", 16'h0028, 32'd3);
    rd("fl_pushcnt0", 16'h0030, 32'd0);
    wr("pc_p1", 16'h0020, 32'h11);
    wr("pc_p2", 16'h0020, 32'h22);
`ifdef IP_FIFO_PUSHCNT_EN
    rd("pc_count", 16'h0030, 32'd2);
    wr("pc_clr", 16'h0030, 32'h0);
    rd("pc_cleared", 16'h0030, 32'd0);
`else
    rd("pc_unmapped", 16'h0030, 32'd0);
`endif

    // ---- Simultaneous write and read: treated as a write only
    req(1'b1, 1'b1, 16'h0020, 32'h77, k, q);
    check("wr_rd_ack", {31'b0, k}, 32'd1);
    idle();
    rd("wr_rd_level", 16'h0024, 32'd3);
    @(negedge clk); ctrl = 32'h1;
    @(negedge clk); ctrl = 32'h0;

    // ---- Read immediately after write on an empty FIFO
    req(1'b1, 1'b0, 16'h0020, 32'h55, k, q);
    req(1'b0, 1'b1, 16'h0020, 32'h0, k, q);
    check("raw_ack", {31'b0, k}, 32'd1);
    check("raw_data", q, 32'h55);
    idle();

    // ---- Unmapped addresses
    wr("unm_wr", 16'h0040, 32'hFFFF_FFFF);
    rd("unm_rd", 16'h0040, 32'h0);
    rd("unm_rd21", 16'h0021, 32'h0);
    rd("unm_level", 16'h0024, 32'd0);

    // ---- Reset while a request is in flight
    wr("mr_push", 16'h0020, 32'h99);
    req(1'b1, 1'b0, 16'h0020, 32'h9A, k, q);
    check("mr_ack_pre", {31'b0, k}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("mr_ack", {31'b0, ack}, 32'd0);
    check("mr_status", status, 32'h0000_0001);
    @(posedge clk); #1;
    check("mr_ack_held", {31'b0, ack}, 32'd0);
    @(negedge clk);
    we = 1'b0; rst_n = 1'b1;
    rd("mr_level", 16'h0024, 32'd0);
    rd("mr_thresh", 16'h0028, 32'd8);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
